seq_shift_add_mult: RTL and testbench

Parametrised sequential shift-and-add multiplier with an integrated controller and a start/done handshake. It multiplies two WIDTH-bit operands into a 2*WIDTH-bit product. Each cycle performs either one add step (only when the current multiplier LSB is 1) or one shift step. It replaces fixed 4-bit accumulator registers that depend on an external controller. It sits between the operand source and any consumer of the product.

---
 rtl/seq_shift_add_mult_if.sv | 33 +++
 rtl/seq_shift_add_mult.sv | 126 ++++++++++++
 tb/tb_seq_shift_add_mult.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/seq_shift_add_mult_if.sv
// Start/done handshake and operand/product bus for seq_shift_add_mult.
// SEQ_MULT_SIGNED_EN adds the signed_mode request bit.
interface seq_shift_add_mult_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;
`ifdef SEQ_MULT_SIGNED_EN
    logic                   signed_mode;

    modport master (
        output start, multiplicand, multiplier, signed_mode,
        input  busy, done, product
    );
    modport slave (
        input  start, multiplicand, multiplier, signed_mode,
        output busy, done, product
    );
`else
    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );
    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
`endif
endinterface

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier: one ADD (multiplier LSB set) or one SHIFT step per cycle.
// Optional macro SEQ_MULT_SIGNED_EN enables two's-complement operands via signed_mode.
module seq_shift_add_mult #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  n_reset,
    seq_shift_add_mult_if.slave   bus
);
    localparam int AW    = 2 * WIDTH + 1;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;
    logic                 sign_q, sign_d;

    logic [WIDTH-1:0]     mcand_op;
    logic [WIDTH-1:0]     mult_op;
    logic                 sign_op;

    // The unsigned core multiplies magnitudes; the sign is reapplied at completion.
    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                       input logic neg);
        return neg ? (~p + (2*WIDTH)'(1)) : p;
    endfunction

`ifdef SEQ_MULT_SIGNED_EN
    // |-2^(W-1)| wraps back to the same bit pattern, which reads as 2^(W-1) unsigned.
    function automatic logic [WIDTH-1:0] abs_op(input logic [WIDTH-1:0] v,
                                                input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    always_comb begin
        mcand_op = abs_op(bus.multiplicand, bus.signed_mode);
        mult_op  = abs_op(bus.multiplier, bus.signed_mode);
        sign_op  = bus.signed_mode & (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
    end
`else
    always_comb begin
        mcand_op = bus.multiplicand;
        mult_op  = bus.multiplier;
        sign_op  = 1'b0;
    end
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        count_d   = count_q;
        product_d = product_q;
        sign_d    = sign_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d   = {(WIDTH + 1)'(0), mult_op};
                    mcand_d = mcand_op;
                    count_d = '0;
                    sign_d  = sign_op;
                    state_d = mult_op[0] ? S_ADD : S_SHIFT;
                end
            end
            S_ADD: begin
                // Carry of the (W+1)-bit sum lands in the top accumulator bit.
                acc_d[2*WIDTH:WIDTH] = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
                state_d              = S_SHIFT;
            end
            S_SHIFT: begin
                acc_d   = {1'b0, acc_q[2*WIDTH:1]};
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    product_d = apply_sign(acc_q[2*WIDTH:1], sign_q);
                end else begin
                    state_d = acc_q[1] ? S_ADD : S_SHIFT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            count_q   <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            sign_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            count_q   <= count_d;
            product_q <= product_d;
            done_q    <= done_d;
            sign_q    <= sign_d;
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed and randomized bench for seq_shift_add_mult at WIDTH=4 and WIDTH=8.
module tb_seq_shift_add_mult;
    logic clk = 1'b0;
    logic n_reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   smode = 1'b0;

`ifdef SEQ_MULT_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    always #5 clk = ~clk;

    seq_shift_add_mult_if #(.WIDTH(4)) b4 ();
    seq_shift_add_mult_if #(.WIDTH(8)) b8 ();

    seq_shift_add_mult #(.WIDTH(4)) dut4 (.clk(clk), .n_reset(n_reset), .bus(b4));
    seq_shift_add_mult #(.WIDTH(8)) dut8 (.clk(clk), .n_reset(n_reset), .bus(b8));

`ifdef SEQ_MULT_SIGNED_EN
    assign b4.signed_mode = smode;
    assign b8.signed_mode = smode;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer product of the operands (sign-extended when signed), truncated to 2W bits.
    function automatic logic [15:0] ref_prod(input int w, input logic [7:0] a,
                                             input logic [7:0] b, input bit sm);
        longint sa, sb, p;
        sa = longint'(a);
        sb = longint'(b);
        if (sm && a[w-1]) sa = sa - (longint'(1) << w);
        if (sm && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        return (w == 4) ? {8'h00, p[7:0]} : p[15:0];
    endfunction

    // Reference: W shift cycles plus one add cycle per set bit of |multiplier|.
    function automatic int ref_lat(input int w, input logic [7:0] b, input bit sm);
        int mag;
        mag = int'(b);
        if (sm && b[w-1]) mag = (1 << w) - mag;
        return w + $countones(mag);
    endfunction

    function automatic logic get_done(input int w);
        return (w == 4) ? b4.done : b8.done;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 4) ? b4.busy : b8.busy;
    endfunction

    function automatic logic [15:0] get_prod(input int w);
        return (w == 4) ? {8'h00, b4.product} : b8.product;
    endfunction

    task automatic drive(input int w, input logic s, input logic [7:0] a, input logic [7:0] b);
        if (w == 4) begin
            b4.start = s; b4.multiplicand = a[3:0]; b4.multiplier = b[3:0];
        end else begin
            b8.start = s; b8.multiplicand = a; b8.multiplier = b;
        end
    endtask

    // Called #1 after an edge: start is accepted on the next edge, then operands are scrambled.
    task automatic start_op(input int w, input logic [7:0] a, input logic [7:0] b, input bit sm);
        smode = sm;
        drive(w, 1'b1, a, b);
        @(posedge clk); #1;
        drive(w, 1'b0, 8'($urandom), 8'($urandom));
    endtask

    task automatic wait_done(input int w, input int n0, input logic [15:0] exp_p,
                             input int exp_lat, input string tag);
        int n;
        n = n0;
        while (get_done(w) !== 1'b1 && n < 2 * w + 4) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'(exp_lat));
        chk({tag, ".product"}, 32'(get_prod(w)), 32'(exp_p));
    endtask

    task automatic run(input int w, input logic [7:0] a, input logic [7:0] b, input bit sm,
                       input logic [15:0] exp_p, input int exp_lat, input string tag);
        @(posedge clk); #1;
        chk({tag, ".idle_done"}, 32'(get_done(w)), 32'd0);
        start_op(w, a, b, sm);
        chk({tag, ".busy"}, 32'(get_busy(w)), 32'd1);
        wait_done(w, 0, exp_p, exp_lat, tag);
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, 32'(get_done(w)), 32'd0);
        chk({tag, ".hold"}, 32'(get_prod(w)), 32'(exp_p));
        chk({tag, ".idle_busy"}, 32'(get_busy(w)), 32'd0);
    endtask

    initial begin
        logic [7:0] a, b;
        bit sm;
        int seen;

        drive(4, 1'b0, 8'h00, 8'h00);
        drive(8, 1'b0, 8'h00, 8'h00);
        #1;
        chk("rst.busy4", 32'(b4.busy), 32'd0);
        chk("rst.done4", 32'(b4.done), 32'd0);
        chk("rst.prod4", 32'(b4.product), 32'd0);
        chk("rst.prod8", 32'(b8.product), 32'd0);
        repeat (2) @(posedge clk);
        #1 n_reset = 1'b1;

        run(4, 8'd13, 8'd11, 1'b0, 16'h008F, 7, "m13x11");
        run(4, 8'd15, 8'd15, 1'b0, 16'h00E1, 8, "m15x15");
        run(4, 8'd9,  8'd0,  1'b0, 16'h0000, 4, "m9x0");
        run(4, 8'd0,  8'd15, 1'b0, 16'h0000, 8, "m0x15");

        // Busy guard, then back-to-back start in the first IDLE cycle after done.
        @(posedge clk); #1;
        start_op(4, 8'd7, 8'd6, 1'b0);
        @(posedge clk); #1;
        drive(4, 1'b1, 8'd3, 8'd3);
        @(posedge clk); #1;
        drive(4, 1'b0, 8'd3, 8'd3);
        wait_done(4, 2, 16'd42, 6, "guard7x6");
        @(posedge clk); #1;
        chk("guard.single_done", 32'(b4.done), 32'd0);
        chk("guard.hold", 32'(b4.product), 32'd42);
        start_op(4, 8'd3, 8'd3, 1'b0);
        wait_done(4, 0, 16'd9, 6, "b2b3x3");

        // Asynchronous reset in the middle of a multiply.
        @(posedge clk); #1;
        start_op(4, 8'd12, 8'd10, 1'b0);
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b0;
        #1;
        chk("midrst.busy", 32'(b4.busy), 32'd0);
        chk("midrst.prod", 32'(b4.product), 32'd0);
        chk("midrst.done", 32'(b4.done), 32'd0);
        repeat (2) @(posedge clk);
        #1 n_reset = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (b4.done === 1'b1) seen++;
        end
        chk("midrst.no_done", 32'(seen), 32'd0);
        run(4, 8'd5, 8'd5, 1'b0, 16'd25, 6, "m5x5");

        run(8, 8'd255, 8'd255, 1'b0, 16'hFE01, 16, "w8_255x255");
        run(8, 8'd128, 8'd1,   1'b0, 16'd128,  9,  "w8_128x1");

        if (SGN) begin
            run(4, 8'h0D, 8'h05, 1'b1, 16'h00F1, 6, "s_m3x5");
            run(4, 8'h08, 8'h08, 1'b1, 16'h0040, 5, "s_m8xm8");
            run(4, 8'h08, 8'h07, 1'b1, 16'h00C8, 7, "s_m8x7");
            run(4, 8'd13, 8'd11, 1'b0, 16'h008F, 7, "s_off13x11");
        end

        for (int i = 0; i < 16; i++) begin
            a  = 8'($urandom_range(0, 15));
            b  = 8'($urandom_range(0, 15));
            sm = SGN && ($urandom_range(0, 1) == 1);
            run(4, a, b, sm, ref_prod(4, a, b, sm), ref_lat(4, b, sm), "rnd4");
        end
        for (int i = 0; i < 8; i++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            sm = SGN && ($urandom_range(0, 1) == 1);
            run(8, a, b, sm, ref_prod(8, a, b, sm), ref_lat(8, b, sm), "rnd8");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
